// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the initiator FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Non-cacheable, non-bufferable, privileged data access.
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ERR
  } state_t;

endpackage

// File: rtl/ahb_lite_master_if.sv
// Command, response and AHB-Lite bus signals of the initiator, with both views.
interface ahb_lite_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_write;
  logic [DATA_W-1:0] cmd_wdata;
  logic [2:0]        cmd_size;
  logic [LEN_W-1:0]  cmd_len;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_last;

  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic              HMASTLOCK;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;
  logic              HRESP;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_size, cmd_len,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_last,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_size, cmd_len,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_last,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_master_addr_gen.sv
// Next-beat address, 1KB boundary NONSEQ/SEQ select and remaining-beat counter.
module ahb_master_addr_gen
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_write,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_advance,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_size,
  output logic [ADDR_W-1:0] o_next_addr,
  output logic [1:0]        o_next_trans,
  output logic              o_last
);
  logic [LEN_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] w_incr;

  assign w_incr       = {{(ADDR_W-1){1'b0}}, 1'b1} << i_size;
  assign o_next_addr  = i_addr + w_incr;
  // Crossing into a new 1KB page restarts the burst with a NONSEQ beat.
  assign o_next_trans = (o_next_addr[9:0] == 10'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
  assign o_last       = (r_cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_write ? '0 : i_len;
    end else if (i_advance && (r_cnt != '0)) begin
      r_cnt <= r_cnt - LEN_W'(1);
    end
  end

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: valid/ready commands in, pipelined AHB transfers out, per-beat responses back.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input logic               HCLK,
  input logic               HRESETn,
  ahb_lite_master_if.master bus
);
  state_t            r_state;
  logic              r_cmd_ready;
  logic              r_dp_act;
  logic [ADDR_W-1:0] r_haddr;
  logic [1:0]        r_htrans;
  logic              r_hwrite;
  logic [2:0]        r_hsize;
  logic [2:0]        r_hburst;
  logic [DATA_W-1:0] r_hwdata;
  logic [DATA_W-1:0] r_wdata_hold;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_last;

  logic [ADDR_W-1:0] w_next_addr;
  logic [1:0]        w_next_trans;
  logic              w_last;
  logic              w_accept;
  logic              w_in_dphase;
  logic              w_err_now;
  logic              w_abort;
  logic              w_advance;

  assign w_accept    = (r_state == ST_IDLE) && bus.cmd_valid;
  assign w_in_dphase = ((r_state == ST_ADDR) && r_dp_act) || (r_state == ST_DATA);
  assign w_err_now   = w_in_dphase && (bus.HRESP == HRESP_ERROR);
  // A one-cycle ERROR and the second cycle of a two-cycle ERROR both end the command.
  assign w_abort     = bus.HREADY && (w_err_now || (r_state == ST_ERR));
  assign w_advance   = (r_state == ST_ADDR) && bus.HREADY && !w_err_now && !w_last;

  ahb_master_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk          (HCLK),
    .rst_n        (HRESETn),
    .i_load       (w_accept),
    .i_write      (bus.cmd_write),
    .i_len        (bus.cmd_len),
    .i_advance    (w_advance),
    .i_addr       (r_haddr),
    .i_size       (r_hsize),
    .o_next_addr  (w_next_addr),
    .o_next_trans (w_next_trans),
    .o_last       (w_last)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state      <= ST_IDLE;
      r_cmd_ready  <= 1'b1;
      r_dp_act     <= 1'b0;
      r_haddr      <= '0;
      r_htrans     <= HTRANS_IDLE;
      r_hwrite     <= 1'b0;
      r_hsize      <= '0;
      r_hburst     <= HBURST_SINGLE;
      r_hwdata     <= '0;
      r_wdata_hold <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
      r_rsp_last   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_last  <= 1'b0;

      if (w_abort) begin
        r_htrans    <= HTRANS_IDLE;
        r_dp_act    <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b1;
        r_rsp_last  <= 1'b1;
        r_rsp_rdata <= '0;
        r_cmd_ready <= 1'b1;
        r_state     <= ST_IDLE;
      end else if (w_err_now) begin
        // First ERROR cycle: cancel the pending address phase right away.
        r_htrans <= HTRANS_IDLE;
        r_dp_act <= 1'b0;
        r_state  <= ST_ERR;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (bus.cmd_valid) begin
              r_cmd_ready  <= 1'b0;
              r_dp_act     <= 1'b0;
              r_haddr      <= bus.cmd_addr;
              r_htrans     <= HTRANS_NONSEQ;
              r_hwrite     <= bus.cmd_write;
              r_hsize      <= bus.cmd_size;
              r_hburst     <= (bus.cmd_write || (bus.cmd_len == '0)) ? HBURST_SINGLE : HBURST_INCR;
              r_wdata_hold <= bus.cmd_wdata;
              r_state      <= ST_ADDR;
            end
          end
          ST_ADDR: begin
            if (bus.HREADY) begin
              // Only reads are ever pipelined behind another beat.
              if (r_dp_act) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= bus.HRDATA;
              end
              if (r_hwrite) r_hwdata <= r_wdata_hold;
              r_dp_act <= 1'b1;
              if (w_last) begin
                r_htrans <= HTRANS_IDLE;
                r_state  <= ST_DATA;
              end else begin
                r_haddr  <= w_next_addr;
                r_htrans <= w_next_trans;
              end
            end
          end
          ST_DATA: begin
            if (bus.HREADY) begin
              r_rsp_valid <= 1'b1;
              r_rsp_last  <= 1'b1;
              r_rsp_rdata <= r_hwrite ? '0 : bus.HRDATA;
              r_cmd_ready <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end
          ST_ERR: ;
        endcase
      end
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_last  = r_rsp_last;
  assign bus.HADDR     = r_haddr;
  assign bus.HTRANS    = r_htrans;
  assign bus.HWRITE    = r_hwrite;
  assign bus.HSIZE     = r_hsize;
  assign bus.HBURST    = r_hburst;
  assign bus.HPROT     = HPROT_DEFAULT;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HWDATA    = r_hwdata;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: AHB slave model with waits/errors and a response/address scoreboard.
module tb_ahb_lite_master;
  import ahb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_lite_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  ahb_lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        last;
  } rsp_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic        write;
    logic [2:0]  size;
  } adr_exp_t;

  rsp_exp_t exp_rsp[$];
  adr_exp_t exp_adr[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Slave behaviour for the current command, set by the stimulus process.
  int          cfg_err_beat  = 0;
  int          cfg_wait_beat = 0;
  int          cfg_wait_n    = 0;
  logic [31:0] cfg_wdata     = '0;

  // ---------------- AHB slave model ----------------
  logic        s_prev_hready = 1'b1;
  logic        s_prev_hold   = 1'b0;
  logic [31:0] s_prev_addr   = '0;
  logic [1:0]  s_prev_trans  = HTRANS_IDLE;
  logic        s_cap_valid   = 1'b0;
  logic [31:0] s_cap_addr    = '0;
  logic        s_cap_write   = 1'b0;
  logic        s_dp_valid    = 1'b0;
  logic [31:0] s_dp_addr     = '0;
  logic        s_dp_write    = 1'b0;
  int          s_beat        = 0;
  int          s_wait        = 0;
  int          s_err_stage   = 0;
  logic        s_hr;
  logic        s_hp;
  logic [31:0] s_rd;
  adr_exp_t    s_ea;

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      s_prev_hready = 1'b1;
      s_prev_hold   = 1'b0;
      s_cap_valid   = 1'b0;
      s_dp_valid    = 1'b0;
      s_beat        = 0;
      s_wait        = 0;
      s_err_stage   = 0;
      bus.HREADY    = 1'b1;
      bus.HRESP     = HRESP_OKAY;
      bus.HRDATA    = '0;
    end else begin
      if (bus.cmd_ready) s_beat = 0;
      // The address phase seen last cycle becomes the data phase if HREADY was high.
      if (s_prev_hready) begin
        s_dp_valid  = s_cap_valid;
        s_dp_addr   = s_cap_addr;
        s_dp_write  = s_cap_write;
        s_err_stage = 0;
        if (s_cap_valid) begin
          s_beat++;
          s_wait = (s_beat == cfg_wait_beat) ? cfg_wait_n : 0;
        end
      end
      if (s_prev_hold && (s_prev_trans != HTRANS_IDLE)) begin
        check("hold_haddr", bus.HADDR, s_prev_addr);
        check("hold_htrans", bus.HTRANS, s_prev_trans);
      end

      s_hr = 1'b1;
      s_hp = HRESP_OKAY;
      s_rd = '0;
      if (s_dp_valid) begin
        if (s_dp_write) check("hwdata", bus.HWDATA, cfg_wdata);
        if (s_err_stage == 1) begin
          check("htrans_after_err", bus.HTRANS, HTRANS_IDLE);
          s_hp        = HRESP_ERROR;
          s_err_stage = 2;
        end else if ((s_err_stage == 0) && (s_beat == cfg_err_beat)) begin
          s_hr        = 1'b0;
          s_hp        = HRESP_ERROR;
          s_err_stage = 1;
        end else if (s_wait > 0) begin
          s_hr = 1'b0;
          s_wait--;
        end else if (!s_dp_write) begin
          s_rd = rom(s_dp_addr);
        end
      end
      bus.HREADY = s_hr;
      bus.HRESP  = s_hp;
      bus.HRDATA = s_rd;

      if ((bus.HTRANS != HTRANS_IDLE) && s_hr) begin
        if (exp_adr.size() == 0) begin
          check("adr_unexpected", bus.HTRANS, HTRANS_IDLE);
        end else begin
          s_ea = exp_adr.pop_front();
          check("haddr", bus.HADDR, s_ea.addr);
          check("htrans", bus.HTRANS, s_ea.trans);
          check("hburst", bus.HBURST, s_ea.burst);
          check("hwrite", bus.HWRITE, s_ea.write);
          check("hsize", bus.HSIZE, s_ea.size);
        end
      end

      s_cap_valid   = (bus.HTRANS != HTRANS_IDLE);
      s_cap_addr    = bus.HADDR;
      s_cap_write   = bus.HWRITE;
      s_prev_hready = s_hr;
      s_prev_hold   = !s_hr && (s_hp == HRESP_OKAY);
      s_prev_addr   = bus.HADDR;
      s_prev_trans  = bus.HTRANS;
    end
  end

  // ---------------- response monitor ----------------
  rsp_exp_t m_r;

  always @(negedge HCLK) begin
    if (bus.rsp_valid) begin
      if (exp_rsp.size() == 0) begin
        check("rsp_unexpected", bus.rsp_valid, 1'b0);
      end else begin
        m_r = exp_rsp.pop_front();
        check("rsp_err", bus.rsp_err, m_r.err);
        check("rsp_last", bus.rsp_last, m_r.last);
        if (!m_r.err) check("rsp_rdata", bus.rsp_rdata, m_r.rdata);
        if (bus.rsp_last) check("cmd_ready_at_last", bus.cmd_ready, 1'b1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue_cmd(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                           input logic [2:0] size, input logic [3:0] len,
                           input int err_beat, input int wait_beat, input int wait_n);
    int       beats;
    int       nb;
    bit       ok;
    rsp_exp_t er;
    adr_exp_t ea;
    beats = write ? 1 : int'(len) + 1;
    nb    = ((err_beat > 0) && (err_beat <= beats)) ? err_beat : beats;
    cfg_err_beat  = err_beat;
    cfg_wait_beat = wait_beat;
    cfg_wait_n    = wait_n;
    cfg_wdata     = wdata;
    for (int i = 0; i < nb; i++) begin
      ea.addr  = addr + (32'(i) << size);
      ea.trans = ((i == 0) || (ea.addr[9:0] == 10'd0)) ? HTRANS_NONSEQ : HTRANS_SEQ;
      ea.burst = (write || (len == 4'd0)) ? HBURST_SINGLE : HBURST_INCR;
      ea.write = write;
      ea.size  = size;
      exp_adr.push_back(ea);
      er.rdata = write ? 32'h0 : rom(ea.addr);
      er.err   = (err_beat > 0) && (i == nb - 1);
      er.last  = (i == nb - 1);
      exp_rsp.push_back(er);
    end
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge HCLK);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("cmd_ready_wait", ok, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_write = write;
    bus.cmd_wdata = wdata;
    bus.cmd_size  = size;
    bus.cmd_len   = len;
    @(posedge HCLK);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; (c < 300) && (exp_rsp.size() != 0); c++) @(negedge HCLK);
    repeat (2) @(negedge HCLK);
    check("rsp_pending", exp_rsp.size(), 0);
    check("adr_pending", exp_adr.size(), 0);
    check("cmd_ready_idle", bus.cmd_ready, 1'b1);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_htrans"}, bus.HTRANS, HTRANS_IDLE);
    check({pfx, "_haddr"}, bus.HADDR, 32'h0);
    check({pfx, "_hwrite"}, bus.HWRITE, 1'b0);
    check({pfx, "_hsize"}, bus.HSIZE, 3'd0);
    check({pfx, "_hburst"}, bus.HBURST, 3'd0);
    check({pfx, "_hwdata"}, bus.HWDATA, 32'h0);
    check({pfx, "_hprot"}, bus.HPROT, 4'b0011);
    check({pfx, "_hmastlock"}, bus.HMASTLOCK, 1'b0);
    check({pfx, "_cmd_ready"}, bus.cmd_ready, 1'b1);
    check({pfx, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    check({pfx, "_rsp_err"}, bus.rsp_err, 1'b0);
    check({pfx, "_rsp_last"}, bus.rsp_last, 1'b0);
    check({pfx, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_write = 1'b0;
    bus.cmd_wdata = '0;
    bus.cmd_size  = HSIZE_WORD;
    bus.cmd_len   = '0;
    repeat (3) @(negedge HCLK);
    check_reset("rst");
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Single word read from ROM, exact latency.
    issue_cmd(32'h0000_0100, 1'b0, 32'h0, HSIZE_WORD, 4'd0, 0, 0, 0);
    check("t1_htrans", bus.HTRANS, HTRANS_NONSEQ);
    check("t1_haddr", bus.HADDR, 32'h0000_0100);
    check("t1_hburst", bus.HBURST, HBURST_SINGLE);
    @(posedge HCLK);
    @(posedge HCLK);
    #1;
    check("t1_rsp_valid", bus.rsp_valid, 1'b1);
    check("t1_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    wait_drain();

    // 4-beat INCR read with two wait states on beat 2.
    issue_cmd(32'h0000_0010, 1'b0, 32'h0, HSIZE_WORD, 4'd3, 0, 2, 2);
    wait_drain();

    // 1KB boundary inside a word burst and inside a halfword burst.
    issue_cmd(32'h0000_03F8, 1'b0, 32'h0, HSIZE_WORD, 4'd3, 0, 0, 0);
    wait_drain();
    issue_cmd(32'h0000_07FE, 1'b0, 32'h0, HSIZE_HALF, 4'd2, 0, 0, 0);
    wait_drain();

    // Byte reads, 3 beats.
    issue_cmd(32'h0000_0041, 1'b0, 32'h0, HSIZE_BYTE, 4'd2, 0, 1, 3);
    wait_drain();

    // Write to ROM answered with a two-cycle ERROR.
    issue_cmd(32'h0000_0020, 1'b1, 32'h1234_5678, HSIZE_WORD, 4'd5, 1, 0, 0);
    wait_drain();

    // Successful write with a wait state; len is ignored for writes.
    issue_cmd(32'h0000_0040, 1'b1, 32'hCAFE_F00D, HSIZE_WORD, 4'd7, 0, 1, 2);
    wait_drain();

    // 8-beat read, ERROR on beat 3.
    issue_cmd(32'h0000_0200, 1'b0, 32'h0, HSIZE_WORD, 4'd7, 3, 0, 0);
    wait_drain();

    // Asynchronous reset in the middle of a stalled burst.
    issue_cmd(32'h0000_0080, 1'b0, 32'h0, HSIZE_WORD, 4'd7, 0, 2, 20);
    repeat (3) @(posedge HCLK);
    #2;
    HRESETn = 1'b0;
    #1;
    check_reset("rst_mid");
    exp_rsp.delete();
    exp_adr.delete();
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    issue_cmd(32'h0000_0100, 1'b0, 32'h0, HSIZE_WORD, 4'd1, 0, 0, 0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
